// File: rtl/fiber_cmd_tx_if.sv
// rtl/fiber_cmd_tx_if.sv - command/line bundle between a fiber command source and fiber_cmd_tx
//
// Purpose: groups the command inputs and the serial line outputs of fiber_cmd_tx.
// Signals:
//   tx_en         1  frames may be started
//   start_stop    1  unit run command
//   igbt_control  2  bridge switching command
//   bypcon        1  bypass-close command
//   reset_unit    1  fault-reset request (one-clk pulse is enough)
//   COMM_T        1  serial fiber line, idle high
//   busy          1  frame or trailing gap in progress
//   frame_sent    1  one-clk pulse at the end of each stop bit
// Modports: master drives commands and observes the line; slave is the transmitter.
interface fiber_cmd_tx_if;
  logic       tx_en;
  logic       start_stop;
  logic [1:0] igbt_control;
  logic       bypcon;
  logic       reset_unit;
  logic       COMM_T;
  logic       busy;
  logic       frame_sent;

  modport master (
    output tx_en, start_stop, igbt_control, bypcon, reset_unit,
    input  COMM_T, busy, frame_sent
  );

  modport slave (
    input  tx_en, start_stop, igbt_control, bypcon, reset_unit,
    output COMM_T, busy, frame_sent
  );
endinterface

// File: rtl/fiber_cmd_tx.sv
// rtl/fiber_cmd_tx.sv - 11-bit serial command frame transmitter for the fiber link
//
// Purpose: sends frames start(0), payload[0..7] LSB first, even parity, stop(1),
// each bit BIT_CYC clks, followed by MIN_GAP idle bit periods. A frame is started on a
// command change, a pending fault-reset request, the first frame after reset, or when
// KEEPALIVE_US time_1us pulses have passed since the previous frame start.
// Payload: [0] start_stop, [2:1] igbt_control, [3] bypcon, [4] reset flag, [7:5] sequence.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   time_1us  one-clk pulse every microsecond
//   bus       fiber_cmd_tx_if.slave: commands in, COMM_T/busy/frame_sent out
// MIN_GAP is expected to be at least 1.
module fiber_cmd_tx #(
  parameter int BIT_CYC      = 20,
  parameter int KEEPALIVE_US = 20,
  parameter int MIN_GAP      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          time_1us,
  fiber_cmd_tx_if.slave bus
);
  localparam int FRAME_BITS = 11;
  localparam int GAP_CYC    = MIN_GAP * BIT_CYC;
  localparam int CNT_MAX    = (GAP_CYC > BIT_CYC) ? GAP_CYC : BIT_CYC;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int KW         = $clog2(KEEPALIVE_US + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [KW-1:0] KA_MAX   = KW'(KEEPALIVE_US);
  localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic          tx_en_q;
  logic [3:0]    cmd_q;
  logic [3:0]    snap;
  logic          go_q;
  logic [KW-1:0] ka_cnt;
  logic [2:0]    seq;
  logic          first_flag;
  logic          pend_flag;
  logic          rst_flag;
  logic [9:0]    shreg;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cyc;
  logic          comm_t;
  logic          busy_r;
  logic          frame_sent_r;

  logic [3:0]    cmd_in;
  logic          trigger;
  logic [7:0]    payload;
  logic [10:0]   frame;

  assign cmd_in  = {bus.bypcon, bus.igbt_control, bus.start_stop};
  assign trigger = tx_en_q && ((ka_cnt == KA_MAX) || (cmd_q != snap) ||
                               rst_flag || first_flag || pend_flag);
  assign payload = {seq, rst_flag, cmd_q};
  assign frame   = {1'b1, ^payload, payload, 1'b0};

  assign bus.COMM_T     = comm_t;
  assign bus.busy       = busy_r;
  assign bus.frame_sent = frame_sent_r;

  // Inputs are registered once and the start decision is registered again, so a
  // command change sampled on one edge drives the start bit two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q <= 1'b0;
      cmd_q   <= 4'd0;
      go_q    <= 1'b0;
    end else begin
      tx_en_q <= bus.tx_en;
      cmd_q   <= cmd_in;
      go_q    <= trigger;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      snap         <= 4'd0;
      ka_cnt       <= '0;
      seq          <= 3'd0;
      first_flag   <= 1'b1;
      pend_flag    <= 1'b0;
      rst_flag     <= 1'b0;
      shreg        <= '1;
      bit_idx      <= 4'd0;
      cyc          <= '0;
      comm_t       <= 1'b1;
      busy_r       <= 1'b0;
      frame_sent_r <= 1'b0;
    end else begin
      frame_sent_r <= 1'b0;

      if (state == IDLE && !tx_en_q) begin
        ka_cnt <= '0;
      end else if (time_1us && ka_cnt != KA_MAX) begin
        ka_cnt <= ka_cnt + KW'(1);
      end

      if (state != IDLE && cmd_q != snap) begin
        pend_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          comm_t <= 1'b1;
          if (go_q) begin
            state      <= SEND;
            snap       <= cmd_q;
            shreg      <= frame[10:1];
            comm_t     <= frame[0];
            bit_idx    <= 4'd0;
            cyc        <= '0;
            busy_r     <= 1'b1;
            ka_cnt     <= '0;
            first_flag <= 1'b0;
            pend_flag  <= 1'b0;
            rst_flag   <= 1'b0;
          end
        end
        SEND: begin
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (bit_idx == STOP_IDX) begin
              state        <= GAP;
              comm_t       <= 1'b1;
              frame_sent_r <= 1'b1;
              seq          <= seq + 3'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              comm_t  <= shreg[0];
              shreg   <= {1'b1, shreg[9:1]};
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        GAP: begin
          comm_t <= 1'b1;
          if (cyc == GAP_LAST) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            cyc    <= '0;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          comm_t <= 1'b1;
          busy_r <= 1'b0;
        end
      endcase

      // Set after the start-of-frame clear so a request landing on that edge
      // is carried by the following frame instead of being dropped.
      if (bus.reset_unit) begin
        rst_flag <= 1'b1;
      end
    end
  end
endmodule
